// File: rtl/branch_predictor.sv
// Dynamic branch predictor: per-PC saturating direction counters with an init sweep.
// Optional branch target buffer is enabled by defining BPU_BTB_EN.
module branch_predictor #(
  parameter int ADDR_W    = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CTR_W     = 2,
  parameter int INIT_CTR  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pred_pc_i,
  output logic              pred_taken_o,
  output logic              pred_hit_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_pred_taken_i,
  output logic              ready_o,
  output logic [15:0]       upd_cnt_o,
  output logic [15:0]       mispred_cnt_o
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] INIT_V = CTR_W'(INIT_CTR);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BHT_DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [15:0]      upd_cnt;
  logic [15:0]      mispred_cnt;
  logic [CTR_W-1:0] ctr [BHT_DEPTH];

  logic [IDX_W-1:0] pidx;
  logic [IDX_W-1:0] uidx;
  logic             run;
  logic             upd_en;

  function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] c, input logic taken);
    if (taken) return (c == '1) ? c : c + 1'b1;
    else       return (c == '0) ? c : c - 1'b1;
  endfunction

  function automatic logic [15:0] sat16_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  assign pidx   = pred_pc_i[IDX_W+1:2];
  assign uidx   = upd_pc_i[IDX_W+1:2];
  assign run    = (state == RUN);
  assign upd_en = run && upd_valid_i && !rst;

  assign ready_o       = run;
  assign upd_cnt_o     = upd_cnt;
  assign mispred_cnt_o = mispred_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      ptr         <= '0;
      upd_cnt     <= '0;
      mispred_cnt <= '0;
    end else if (!run) begin
      ptr <= ptr + 1'b1;
      if (ptr == LAST_IDX) state <= RUN;
    end else if (upd_valid_i) begin
      upd_cnt <= sat16_inc(upd_cnt);
      if (upd_pred_taken_i != upd_taken_i) mispred_cnt <= sat16_inc(mispred_cnt);
    end
  end

  // Counter storage carries no reset; the sweep initialises every entry.
  always_ff @(posedge clk) begin
    if (!run) ctr[ptr] <= INIT_V;
    else if (upd_en) ctr[uidx] <= ctr_next(ctr[uidx], upd_taken_i);
  end

`ifdef BPU_BTB_EN
  logic              btb_valid [BHT_DEPTH];
  logic [TAG_W-1:0]  btb_tag   [BHT_DEPTH];
  logic [ADDR_W-1:0] btb_tgt   [BHT_DEPTH];
  logic              hit;
  logic              unused_bits;

  always_ff @(posedge clk) begin
    if (!run) begin
      btb_valid[ptr] <= 1'b0;
    end else if (upd_en && upd_taken_i) begin
      btb_valid[uidx] <= 1'b1;
      btb_tag[uidx]   <= upd_pc_i[ADDR_W-1:IDX_W+2];
      btb_tgt[uidx]   <= upd_target_i;
    end
  end

  assign hit = run && btb_valid[pidx] && (btb_tag[pidx] == pred_pc_i[ADDR_W-1:IDX_W+2]);
  assign pred_hit_o    = hit;
  assign pred_target_o = hit ? btb_tgt[pidx] : '0;
  assign pred_taken_o  = hit && ctr[pidx][CTR_W-1];
  assign unused_bits   = ^{pred_pc_i[1:0], upd_pc_i[1:0]};
`else
  logic unused_bits;

  assign pred_hit_o    = 1'b0;
  assign pred_target_o = '0;
  assign pred_taken_o  = run && ctr[pidx][CTR_W-1];
  assign unused_bits   = ^{pred_pc_i[ADDR_W-1:IDX_W+2], pred_pc_i[1:0],
                           upd_pc_i[ADDR_W-1:IDX_W+2], upd_pc_i[1:0], upd_target_i};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Randomised self-checking bench for branch_predictor against a reference model.
// Define BPU_BTB_EN at compile time to also check the branch target buffer.
module tb_branch_predictor;

  localparam int DEPTH = 64;
  localparam int MAXC  = 3;
  localparam int HALF  = 2;
  localparam int INITC = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        pred_taken;
  logic        pred_hit;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_pred_taken = 1'b0;
  logic        ready;
  logic [15:0] upd_cnt;
  logic [15:0] mispred_cnt;

  branch_predictor #(.ADDR_W(32), .BHT_DEPTH(DEPTH), .CTR_W(2), .INIT_CTR(INITC)) dut (
    .clk(clk), .rst(rst),
    .pred_pc_i(pred_pc), .pred_taken_o(pred_taken), .pred_hit_o(pred_hit),
    .pred_target_o(pred_target),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_pred_taken_i(upd_pred_taken),
    .ready_o(ready), .upd_cnt_o(upd_cnt), .mispred_cnt_o(mispred_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  bit chk_on = 0;

  // Reference model: plain integers, clamped arithmetic
  int  m_ctr [DEPTH];
  bit  m_valid [DEPTH];
  int  m_tag [DEPTH];
  int  m_tgt [DEPTH];
  bit  m_ready = 0;
  int  m_swept = 0;
  int  m_upd = 0;
  int  m_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % DEPTH);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'(pc / (4 * DEPTH));
  endfunction

  function automatic bit exp_hit(input logic [31:0] pc);
`ifdef BPU_BTB_EN
    return m_ready && m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
`else
    return 0;
`endif
  endfunction

  function automatic bit exp_taken(input logic [31:0] pc);
    bit dir;
    dir = m_ready && (m_ctr[idx_of(pc)] >= HALF);
`ifdef BPU_BTB_EN
    return dir && exp_hit(pc);
`else
    return dir;
`endif
  endfunction

  task automatic compare_outputs();
    check_val("ready", ready, m_ready);
    check_val("pred_taken", pred_taken, exp_taken(pred_pc));
    check_val("pred_hit", pred_hit, exp_hit(pred_pc));
    check_val("pred_target", pred_target, exp_hit(pred_pc) ? m_tgt[idx_of(pred_pc)] : 0);
    check_val("upd_cnt", upd_cnt, m_upd);
    check_val("mispred_cnt", mispred_cnt, m_mis);
  endtask

  task automatic model_step();
    int i;
    if (rst) begin
      m_ready = 0; m_swept = 0; m_upd = 0; m_mis = 0;
    end else if (!m_ready) begin
      m_ctr[m_swept] = INITC;
      m_valid[m_swept] = 0;
      m_swept++;
      if (m_swept == DEPTH) m_ready = 1;
    end else if (upd_valid) begin
      i = idx_of(upd_pc);
      if (upd_taken) begin
        m_ctr[i] = (m_ctr[i] + 1 > MAXC) ? MAXC : m_ctr[i] + 1;
        m_valid[i] = 1;
        m_tag[i] = tag_of(upd_pc);
        m_tgt[i] = int'(upd_target);
      end else begin
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end
      m_upd = (m_upd + 1 > 65535) ? 65535 : m_upd + 1;
      if (upd_taken != upd_pred_taken) m_mis = (m_mis + 1 > 65535) ? 65535 : m_mis + 1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (chk_on) compare_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] t, i, l;
    t = $urandom_range(0, 2);
    i = $urandom_range(0, DEPTH - 1);
    l = $urandom_range(0, 3);
    return (t << 8) | (i << 2) | l;
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready && n < 200) begin
      pred_pc = rand_pc();
      upd_valid = 1'(($urandom % 2));
      upd_pc = rand_pc();
      upd_taken = 1'($urandom % 2);
      cycle();
      n++;
    end
    upd_valid = 1'b0;
    check_val(tag, n, DEPTH);
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = taken; upd_target = tgt;
    upd_pred_taken = 1'b0;
    cycle();
    upd_valid = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    cycle();
    chk_on = 1;
    rst = 1'b0;
    check_val("reset_ready", ready, 0);
    check_val("reset_upd_cnt", upd_cnt, 0);
    check_val("reset_mis_cnt", mispred_cnt, 0);
    wait_ready("sweep_len");

    // Restart a sweep partway through
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    wait_ready("sweep_restart_len");

    pred_pc = 32'h40;
    do_upd(32'h40, 1'b1, 32'h100);
    check_val("taken_once_0x40", pred_taken, 1);
`ifdef BPU_BTB_EN
    check_val("btb_hit_0x40", pred_hit, 1);
    check_val("btb_target_0x40", pred_target, 32'h100);
    pred_pc = 32'h140;
    #1;
    check_val("alias_hit_0x140", pred_hit, 0);
    check_val("alias_taken_0x140", pred_taken, 0);
`else
    check_val("nobtb_hit_0x40", pred_hit, 0);
    check_val("nobtb_target_0x40", pred_target, 0);
    pred_pc = 32'h140;
    #1;
    check_val("alias_taken_0x140", pred_taken, 1);
`endif
    pred_pc = 32'h40;
    for (int k = 0; k < 4; k++) do_upd(32'h40, 1'b1, 32'h100);
    check_val("sat_hi_0x40", pred_taken, 1);
    do_upd(32'h40, 1'b0, 32'h0);
    check_val("dec_from_3_0x40", pred_taken, 1);
    do_upd(32'h40, 1'b0, 32'h0);
    check_val("dec_to_1_0x40", pred_taken, 0);

    // Same-cycle lookup and update at 0x80
    pred_pc = 32'h80;
    upd_valid = 1'b1; upd_pc = 32'h80; upd_taken = 1'b1; upd_target = 32'h200;
    #1;
    check_val("same_cycle_old", pred_taken, 0);
    cycle();
    upd_valid = 1'b0;
    #1;
    check_val("same_cycle_new", pred_taken, 1);

    for (int k = 0; k < 2000; k++) begin
      pred_pc = rand_pc();
      upd_valid = 1'($urandom % 2);
      upd_pc = rand_pc();
      upd_taken = 1'($urandom % 2);
      upd_target = $urandom & 32'hFFFF_FFFC;
      upd_pred_taken = 1'($urandom % 2);
      cycle();
    end

    for (int k = 0; k < 65540; k++) begin
      upd_valid = 1'b1;
      upd_pc = rand_pc();
      upd_taken = 1'($urandom % 2);
      upd_pred_taken = ~upd_taken;
      upd_target = $urandom & 32'hFFFF_FFFC;
      pred_pc = rand_pc();
      cycle();
    end
    upd_valid = 1'b0;
    check_val("upd_cnt_sat", upd_cnt, 16'hFFFF);
    check_val("mis_cnt_sat", mispred_cnt, 16'hFFFF);

    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_val("post_rst_upd_cnt", upd_cnt, 0);
    check_val("post_rst_mis_cnt", mispred_cnt, 0);
    check_val("post_rst_ready", ready, 0);
    wait_ready("sweep_len_final");
    cycle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the pipelined MIPS core. It replaces the static "predict not-taken, flush IF/ID on a resolved beq" scheme with a table of per-PC saturating counters. The table is looked up combinationally with the IF-stage PC and updated from the ID stage, where beq is resolved. It carries an init sweep FSM, optional branch target buffer (BTB) and saturating statistics counters.

## Interface
- ADDR_W, 32, PC width in bits.
- BHT_DEPTH, 64, number of counter entries; power of two, at least 2; IDX_W = log2(BHT_DEPTH).
- CTR_W, 2, saturating counter width in bits, at least 1.
- INIT_CTR, 1, counter value written to every entry by the init sweep ("weakly not-taken" at CTR_W=2).
- clk, in, 1, clock; rising edge.
- rst, in, 1, reset; synchronous, active-high.
- pred_pc_i, in, ADDR_W, IF-stage PC to look up.
- pred_taken_o, out, 1, prediction for pred_pc_i.
- pred_hit_o, out, 1, BTB tag hit for pred_pc_i.
- pred_target_o, out, ADDR_W, predicted target.
- upd_valid_i, in, 1, a branch resolved in ID this cycle.
- upd_pc_i, in, ADDR_W, PC of the resolved branch.
- upd_taken_i, in, 1, resolved direction.
- upd_target_i, in, ADDR_W, resolved target (PC+4+offset<<2).
- upd_pred_taken_i, in, 1, prediction originally issued for this branch, pipelined from IF.
- ready_o, out, 1, init sweep complete.
- upd_cnt_o, out, 16, number of accepted updates; saturating.
- mispred_cnt_o, out, 16, number of accepted direction mispredicts; saturating.

## Operation
- Index = pc[IDX_W+1:2]. Tag = pc[ADDR_W-1:IDX_W+2]. The two LSBs are ignored.
- FSM has two states, INIT and RUN.
  - rst high forces INIT with sweep pointer = 0. rst has priority over everything, including a sweep already in progress, which restarts at entry 0.
  - In INIT, each edge writes INIT_CTR to entry[ptr], clears BTB valid[ptr], then increments ptr.
  - After entry BHT_DEPTH-1 is written, the FSM moves to RUN.
- ready_o = (state == RUN).
- While in INIT:
  - pred_taken_o = 0, pred_hit_o = 0, pred_target_o = 0.
  - Updates are ignored and not counted.
- Prediction in RUN is combinational from the registered arrays:
  - pred_taken_o = counter[idx][CTR_W-1], gated by pred_hit_o when BPU_BTB_EN is defined.
- Update (RUN, upd_valid_i = 1), at the edge:
  - The counter at upd index increments if taken, decrements if not taken.
  - Saturation: the counter stays at 2^CTR_W-1 on taken and stays at 0 on not-taken.
  - upd_cnt_o increments by 1.
  - mispred_cnt_o increments by 1 when upd_pred_taken_i != upd_taken_i.
  - Both statistics counters hold at 0xFFFF.
- Aliasing: PCs with the same index share one counter. No tag check is made on the counters.

## Timing
- Reset values, in the cycle after the rst edge: ready_o = 0, all prediction outputs 0, upd_cnt_o = 0, mispred_cnt_o = 0.
- ready_o first reads 1 exactly BHT_DEPTH cycles after the last cycle rst is sampled high.
- Lookup latency is 0 cycles (same cycle as pred_pc_i). This matches the combinational instruction fetch.
- Update latency is 1 cycle: a write at edge N is visible to lookups from cycle N onward.
- A lookup and an update to the same index in the same cycle returns the old value. There is no bypass.
- An update and a stall or flush of the pipeline are independent. The CPU presents each resolved branch exactly once.

## Configuration
- BPU_BTB_EN defined:
  - Adds per-entry valid, tag and target arrays.
  - pred_hit_o = valid[idx] && tag match.
  - pred_target_o = target[idx] on a hit, else 0.
  - On an update with upd_taken_i = 1: writes valid = 1, the tag of upd_pc_i, and upd_target_i. A not-taken update leaves the BTB entry unchanged.
  - The init sweep clears valid.
- BPU_BTB_EN undefined:
  - No BTB storage.
  - pred_hit_o = 0 and pred_target_o = 0 constantly.
  - pred_taken_o is direction only, for the ID-stage early redirect.

## Test plan
- Defaults: pulse rst for 1 cycle, count cycles until ready_o -> 64; pred_taken_o = 0 for every PC during the sweep.
- Defaults: reassert rst at sweep cycle 20 -> ready_o rises 64 cycles after the release.
- Defaults, no BTB: one taken update at 0x40 -> pred_taken_o(0x40) = 1. Then 4 more taken and 2 not-taken -> counter 3 then 1, pred_taken_o = 0.
- Same-cycle update and lookup at 0x80, taken -> pred_taken_o = 0 that cycle and 1 the next.
- BPU_BTB_EN: taken update at 0x40 with target 0x100 -> pred_hit_o = 1 and pred_target_o = 0x100 at 0x40. 0x140 (same index, different tag) -> pred_hit_o = 0 and pred_taken_o = 0.
- 65,540 updates with upd_pred_taken_i != upd_taken_i -> mispred_cnt_o = upd_cnt_o = 0xFFFF, then rst -> both read 0.
